pwm_carrier_gen: RTL and testbench

Carrier (time-base) generator for the CPWM core. Produces the up, down or up-down counter that the downstream compare and dead-time stages consume, together with min/max event strobes, a shadow-register load strobe and a decimated interrupt pulse. All mode inputs use the encodings in `PKG_pwm`: `_count_mode`, `_mask_mode`, `_pwm_onoff`, `_int_onoff` and `_clkdiv_onoff`.

---
 rtl/pwm_carrier_gen.sv | 260 ++++++++++++++++++++++++++
 tb/tb_pwm_carrier_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_carrier_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_carrier_gen
// Purpose  : CPWM carrier time base. Shadowed period/mode, up/down/up-down
//            counting, min/max/load strobes and a decimated interrupt pulse.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_carrier_gen #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 5,
  parameter int INT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_onoff,
  input  logic [1:0]       count_mode,
  input  logic [1:0]       mask_mode,
  input  logic             clkdiv_onoff,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic [CNT_W-1:0] period,
  input  logic             int_onoff,
  input  logic [INT_W-1:0] int_count,
  output logic [CNT_W-1:0] carrier,
  output logic             count_dir,
  output logic             min_evt,
  output logic             max_evt,
  output logic             load_evt,
  output logic             irq
);

  localparam logic       c_PWM_ON       = 1'b1;
  localparam logic       c_CLKDIV_ON    = 1'b1;
  localparam logic       c_INT_ON       = 1'b1;
  localparam logic [1:0] c_COUNT_UP     = 2'b00;
  localparam logic [1:0] c_COUNT_DOWN   = 2'b01;
  localparam logic [1:0] c_COUNT_UPDOWN = 2'b10;
  localparam logic [1:0] c_NO_MASK      = 2'b00;
  localparam logic [1:0] c_MIN_MASK     = 2'b01;
  localparam logic [1:0] c_MAX_MASK     = 2'b10;

  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  // Shadow (active) registers
  logic [CNT_W-1:0] r_period_a;
  logic [1:0]       r_mode_a;

  // Time-base state and registered outputs
  logic [CNT_W-1:0] r_carrier;
  logic             r_dir;
  logic [DIV_W-1:0] r_div_cnt;
  logic [INT_W-1:0] r_int_cnt;
  logic             r_min_evt;
  logic             r_max_evt;
  logic             r_load_evt;
  logic             r_irq;

  logic             w_pwm_on;
  logic             w_tick;
  logic [1:0]       w_mode_in;
  logic [DIV_W-1:0] w_div_next;
  logic [CNT_W:0]   w_inc;
  logic [CNT_W-1:0] w_dec;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_dir_next;
  logic             w_min;
  logic             w_max;
  logic             w_load_evt;
  logic             w_shadow_ld;
  logic             w_mode_chg;

  assign w_pwm_on = (pwm_onoff == c_PWM_ON);

  // The reserved encoding 2'b11 is folded onto COUNT_UP before it is shadowed.
  assign w_mode_in = ((count_mode == c_COUNT_DOWN) || (count_mode == c_COUNT_UPDOWN))
                     ? count_mode : c_COUNT_UP;

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  assign w_tick = w_pwm_on &&
                  ((clkdiv_onoff != c_CLKDIV_ON) || (r_div_cnt >= clkdiv));

  always_comb begin
    w_div_next = '0;
    if (w_pwm_on && (clkdiv_onoff == c_CLKDIV_ON) && (r_div_cnt < clkdiv)) begin
      w_div_next = r_div_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next carrier value and event detection (evaluated for a tick)
  // ---------------------------------------------------------------------------
  assign w_inc = {1'b0, r_carrier} + (CNT_W+1)'(1);
  assign w_dec = r_carrier - c_CNT_ONE;

  always_comb begin
    w_cnt_next = r_carrier;
    w_dir_next = r_dir;
    w_min      = 1'b0;
    w_max      = 1'b0;
    if (r_period_a == '0) begin
      w_cnt_next = '0;
      w_dir_next = (r_mode_a == c_COUNT_DOWN);
      w_min      = 1'b1;
      w_max      = 1'b1;
    end else begin
      case (r_mode_a)
        c_COUNT_DOWN: begin
          w_dir_next = 1'b1;
          if ((r_carrier == '0) || (r_carrier > r_period_a)) begin
            w_cnt_next = r_period_a;
            w_max      = 1'b1;
          end else begin
            w_cnt_next = w_dec;
            w_min      = (w_dec == '0);
          end
        end
        c_COUNT_UPDOWN: begin
          if (!r_dir) begin
            if (w_inc >= {1'b0, r_period_a}) begin
              w_cnt_next = r_period_a;
              w_dir_next = 1'b1;
              w_max      = 1'b1;
            end else begin
              w_cnt_next = w_inc[CNT_W-1:0];
            end
          end else if (r_carrier > r_period_a) begin
            w_cnt_next = r_period_a;
          end else if (r_carrier <= c_CNT_ONE) begin
            // A zero carrier while descending is treated as the valley too.
            w_cnt_next = '0;
            w_dir_next = 1'b0;
            w_min      = 1'b1;
          end else begin
            w_cnt_next = w_dec;
          end
        end
        default: begin
          w_dir_next = 1'b0;
          if (r_carrier >= r_period_a) begin
            w_cnt_next = '0;
            w_min      = 1'b1;
          end else begin
            w_cnt_next = w_inc[CNT_W-1:0];
            w_max      = (w_inc[CNT_W-1:0] == r_period_a);
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow-load selection
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load_evt  = 1'b0;
    w_shadow_ld = 1'b1;
    if (w_pwm_on) begin
      case (mask_mode)
        c_NO_MASK: begin
          w_load_evt  = w_tick && w_min;
          w_shadow_ld = 1'b1;
        end
        c_MIN_MASK: begin
          w_load_evt  = w_tick && w_min;
          w_shadow_ld = w_load_evt;
        end
        c_MAX_MASK: begin
          w_load_evt  = w_tick && w_max;
          w_shadow_ld = w_load_evt;
        end
        default: begin
          w_load_evt  = w_tick && (w_min || w_max);
          w_shadow_ld = w_load_evt;
        end
      endcase
    end
  end

  assign w_mode_chg = w_shadow_ld && (w_mode_in != r_mode_a);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_a <= '0;
      r_mode_a   <= c_COUNT_UP;
    end else if (w_shadow_ld) begin
      r_period_a <= period;
      r_mode_a   <= w_mode_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= w_div_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carrier  <= '0;
      r_dir      <= 1'b0;
      r_min_evt  <= 1'b0;
      r_max_evt  <= 1'b0;
      r_load_evt <= 1'b0;
    end else if (!w_pwm_on) begin
      r_carrier  <= (r_mode_a == c_COUNT_DOWN) ? r_period_a : '0;
      r_dir      <= 1'b0;
      r_min_evt  <= 1'b0;
      r_max_evt  <= 1'b0;
      r_load_evt <= 1'b0;
    end else begin
      r_min_evt  <= w_tick && w_min;
      r_max_evt  <= w_tick && w_max;
      r_load_evt <= w_load_evt;
      if (w_tick) begin
        r_carrier <= w_cnt_next;
      end
      // A newly loaded mode re-seeds the direction over the counting result.
      if (w_mode_chg) begin
        r_dir <= (w_mode_in == c_COUNT_DOWN);
      end else if (w_tick) begin
        r_dir <= w_dir_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_cnt <= '0;
      r_irq     <= 1'b0;
    end else if (!w_pwm_on || (int_onoff != c_INT_ON)) begin
      r_int_cnt <= '0;
      r_irq     <= 1'b0;
    end else if (w_load_evt) begin
      if (r_int_cnt >= int_count) begin
        r_int_cnt <= '0;
        r_irq     <= 1'b1;
      end else begin
        r_int_cnt <= r_int_cnt + INT_W'(1);
        r_irq     <= 1'b0;
      end
    end else begin
      r_irq <= 1'b0;
    end
  end

  assign carrier   = r_carrier;
  assign count_dir = r_dir;
  assign min_evt   = r_min_evt;
  assign max_evt   = r_max_evt;
  assign load_evt  = r_load_evt;
  assign irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_pwm_carrier_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_carrier_gen
// Purpose  : Directed self-checking bench for pwm_carrier_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_carrier_gen;

  localparam int CNT_W = 16;
  localparam int DIV_W = 5;
  localparam int INT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm_onoff = 1'b0;
  logic [1:0]       count_mode = 2'b00;
  logic [1:0]       mask_mode = 2'b00;
  logic             clkdiv_onoff = 1'b0;
  logic [DIV_W-1:0] clkdiv = '0;
  logic [CNT_W-1:0] period = '0;
  logic             int_onoff = 1'b0;
  logic [INT_W-1:0] int_count = '0;
  logic [CNT_W-1:0] carrier;
  logic             count_dir;
  logic             min_evt;
  logic             max_evt;
  logic             load_evt;
  logic             irq;

  int n_checks = 0;
  int n_errors = 0;

  pwm_carrier_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W), .INT_W(INT_W)) dut (
    .clk(clk), .rst(rst), .pwm_onoff(pwm_onoff), .count_mode(count_mode),
    .mask_mode(mask_mode), .clkdiv_onoff(clkdiv_onoff), .clkdiv(clkdiv),
    .period(period), .int_onoff(int_onoff), .int_count(int_count),
    .carrier(carrier), .count_dir(count_dir), .min_evt(min_evt),
    .max_evt(max_evt), .load_evt(load_evt), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Park the block off, apply a configuration and let the shadows settle.
  task automatic configure(input logic [15:0] p, input logic [1:0] cm, input logic [1:0] mm,
                           input logic cdo, input logic [4:0] cd, input logic io,
                           input logic [2:0] ic);
    pwm_onoff    = 1'b0;
    period       = p;
    count_mode   = cm;
    mask_mode    = mm;
    clkdiv_onoff = cdo;
    clkdiv       = cd;
    int_onoff    = io;
    int_count    = ic;
    wait_cyc(3);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({carrier, count_dir, min_evt, max_evt, load_evt, irq} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_held: carrier=%0d dir=%b strobes=%b%b%b%b, expected all 0",
               carrier, count_dir, min_evt, max_evt, load_evt, irq);
    end
    rst = 1'b0;
    wait_cyc(2);
    n_checks++;
    if ({carrier, count_dir, min_evt, max_evt, load_evt, irq} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_released_off: carrier=%0d dir=%b strobes=%b%b%b%b, expected all 0",
               carrier, count_dir, min_evt, max_evt, load_evt, irq);
    end
  endtask

  task automatic test_up_nomask();
    int exp_c [10];
    exp_c = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    configure(16'd4, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0, 3'd0);
    pwm_onoff = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (carrier !== CNT_W'(exp_c[i]) || max_evt !== (exp_c[i] == 4) ||
          min_evt !== (exp_c[i] == 0) || load_evt !== (exp_c[i] == 0)) begin
        n_errors++;
        $display("FAIL up_nomask[%0d]: carrier=%0d max=%b min=%b load=%b, expected carrier=%0d max=%b min=%b load=%b",
                 i, carrier, max_evt, min_evt, load_evt, exp_c[i], exp_c[i] == 4,
                 exp_c[i] == 0, exp_c[i] == 0);
      end
    end
  endtask

  task automatic test_updown_div();
    int exp_c [15];
    int exp_d [15];
    exp_c = '{0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1, 1};
    exp_d = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    configure(16'd3, 2'b10, 2'b00, 1'b1, 5'd1, 1'b0, 3'd0);
    pwm_onoff = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_checks++;
      if (carrier !== CNT_W'(exp_c[i]) || count_dir !== exp_d[i][0] ||
          max_evt !== (i == 5) || min_evt !== (i == 11)) begin
        n_errors++;
        $display("FAIL updown_div[%0d]: carrier=%0d dir=%b max=%b min=%b, expected carrier=%0d dir=%0d max=%b min=%b",
                 i, carrier, count_dir, max_evt, min_evt, exp_c[i], exp_d[i], i == 5, i == 11);
      end
    end
  endtask

  task automatic test_shadow_period();
    int exp_c [13];
    exp_c = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 2, 3, 0};
    configure(16'd8, 2'b00, 2'b01, 1'b0, 5'd0, 1'b0, 3'd0);
    pwm_onoff = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      n_checks++;
      if (carrier !== CNT_W'(exp_c[i]) || load_evt !== (i == 8 || i == 12)) begin
        n_errors++;
        $display("FAIL shadow_period[%0d]: carrier=%0d load=%b, expected carrier=%0d load=%b",
                 i, carrier, load_evt, exp_c[i], (i == 8 || i == 12));
      end
      if (i == 4) period = 16'd3;
    end
  endtask

  task automatic test_down_maxmask();
    int exp_c [7];
    exp_c = '{1, 0, 2, 1, 0, 2, 1};
    configure(16'd2, 2'b01, 2'b10, 1'b0, 5'd0, 1'b0, 3'd0);
    n_checks++;
    if (carrier !== 16'd2 || count_dir !== 1'b0) begin
      n_errors++;
      $display("FAIL down_off_state: carrier=%0d dir=%b, expected carrier=2 dir=0",
               carrier, count_dir);
    end
    pwm_onoff = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_checks++;
      if (carrier !== CNT_W'(exp_c[i]) || load_evt !== (exp_c[i] == 2) ||
          count_dir !== 1'b1) begin
        n_errors++;
        $display("FAIL down_maxmask[%0d]: carrier=%0d load=%b dir=%b, expected carrier=%0d load=%b dir=1",
                 i, carrier, load_evt, count_dir, exp_c[i], exp_c[i] == 2);
      end
    end
  endtask

  task automatic test_irq_decimation();
    configure(16'd1, 2'b00, 2'b11, 1'b0, 5'd0, 1'b1, 3'd2);
    pwm_onoff = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_checks++;
      if (irq !== ((i % 3) == 2) || load_evt !== 1'b1) begin
        n_errors++;
        $display("FAIL irq_on[%0d]: irq=%b load=%b, expected irq=%b load=1",
                 i, irq, load_evt, (i % 3) == 2);
      end
    end
    int_onoff = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b0) begin
        n_errors++;
        $display("FAIL irq_off[%0d]: irq=%b, expected 0", i, irq);
      end
    end
  endtask

  task automatic test_period_zero_and_off();
    configure(16'd0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0, 3'd0);
    pwm_onoff = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (carrier !== 16'd0 || min_evt !== 1'b1 || max_evt !== 1'b1 || load_evt !== 1'b1) begin
        n_errors++;
        $display("FAIL p_zero[%0d]: carrier=%0d min=%b max=%b load=%b, expected 0 1 1 1",
                 i, carrier, min_evt, max_evt, load_evt);
      end
    end
    pwm_onoff = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({min_evt, max_evt, load_evt, irq} !== 4'b0000) begin
      n_errors++;
      $display("FAIL turn_off_strobes: strobes=%b%b%b%b, expected 0000",
               min_evt, max_evt, load_evt, irq);
    end
  endtask

  task automatic test_async_reset();
    configure(16'd20, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0, 3'd0);
    pwm_onoff = 1'b1;
    wait_cyc(7);
    n_checks++;
    if (carrier !== 16'd7) begin
      n_errors++;
      $display("FAIL async_pre: carrier=%0d, expected 7", carrier);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({carrier, count_dir, min_evt, max_evt, load_evt, irq} !== 21'd0) begin
      n_errors++;
      $display("FAIL async_reset: carrier=%0d dir=%b strobes=%b%b%b%b, expected all 0",
               carrier, count_dir, min_evt, max_evt, load_evt, irq);
    end
    @(negedge clk);
    pwm_onoff = 1'b0;
    rst = 1'b0;
    wait_cyc(2);
    pwm_onoff = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (carrier !== CNT_W'(i + 1)) begin
        n_errors++;
        $display("FAIL async_restart[%0d]: carrier=%0d, expected %0d", i, carrier, i + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_nomask();
    test_updown_div();
    test_shadow_period();
    test_down_maxmask();
    test_irq_decimation();
    test_period_zero_and_off();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
